// File: rtl/tt_um_verilog_meetup_pwm_bank_if.sv
// rtl/tt_um_verilog_meetup_pwm_bank_if.sv - pin bundle between the PWM bank and its driver
interface tt_um_verilog_meetup_pwm_bank_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_verilog_meetup_pwm_bank.sv
// rtl/tt_um_verilog_meetup_pwm_bank.sv - bank of edge-aligned PWM channels with wrap-synchronised duty updates
// Optional: define PWM_BANK_PHASE_STAGGER_EN to spread channel phases evenly over one period.
module tt_um_verilog_meetup_pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
`ifdef PWM_BANK_PHASE_STAGGER_EN
    localparam int STEP = (2 ** WIDTH) / CHANNELS;
`endif

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_shadow [8];
    logic [WIDTH-1:0] r_active [8];
    logic             r_stb;
    logic             r_tick;
    logic             r_ack;
    logic             r_run;
    logic [7:0]       r_pwm;

    logic [WIDTH-1:0] w_cmp [8];
    logic             w_run;
    logic             w_wrap;
    logic             w_edge;
    logic             w_addr_ok;
    logic             w_unused;

    assign w_run     = uio_in[4];
    assign w_wrap    = w_run && (r_cnt == CNT_MAX);
    assign w_edge    = uio_in[3] & ~r_stb;
    assign w_addr_ok = int'(uio_in[2:0]) < CHANNELS;
    assign w_unused  = &{1'b0, ui_in, uio_in[7:5]};

    always_comb begin
        for (int i = 0; i < 8; i++) begin
`ifdef PWM_BANK_PHASE_STAGGER_EN
            w_cmp[i] = r_cnt + WIDTH'(i * STEP);
`else
            w_cmp[i] = r_cnt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_stb  <= 1'b0;
            r_tick <= 1'b0;
            r_ack  <= 1'b0;
            r_run  <= 1'b0;
            r_pwm  <= '0;
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else if (ena) begin
            r_stb  <= uio_in[3];
            r_run  <= w_run;
            r_tick <= w_wrap;
            r_ack  <= w_edge & w_addr_ok;
            if (w_run) begin
                r_cnt <= r_cnt + WIDTH'(1);
                for (int i = 0; i < 8; i++) begin
                    r_pwm[i] <= (i < CHANNELS) && (w_cmp[i] < r_active[i]);
                end
            end
            // active takes the pre-write shadow, so a same-cycle write waits one more period
            for (int i = 0; i < 8; i++) begin
                if (w_wrap && (i < CHANNELS)) begin
                    r_active[i] <= r_shadow[i];
                end
                if (w_edge && w_addr_ok && (uio_in[2:0] == i[2:0])) begin
                    r_shadow[i] <= ui_in[WIDTH-1:0];
                end
            end
        end
    end

    assign uo_out  = r_pwm;
    assign uio_out = {r_run, r_ack, r_tick, 5'b0_0000};
    assign uio_oe  = 8'hE0;
endmodule
